axi_read_arbiter_nxm: RTL and testbench
=======================================

Name: axi_read_arbiter_nxm

Overview:
- Parametrised AXI read-path arbiter/controller for NUM_M masters and NUM_S slaves.
- Arbitrates AR requests and decodes the target slave from an address region field.
- Holds the master/slave pairing through the AR phase and the full R burst, then releases it.
- Includes a built-in decode-error responder. It accepts unmapped reads and returns a DECERR burst of ARLEN+1 beats, so an unmapped address never hangs the bus.

Parameters:
- NUM_M, 2, number of masters (>=2).
- NUM_S, 2, number of mapped slaves (>=1); region r maps to slave r for r < NUM_S.
- ADDR_W, 32, address width.
- REGION_LSB, 16, lowest address bit of the region field; the region field is ARADDR[ADDR_W-1:REGION_LSB].
- MW, $clog2(NUM_M), master index width (derived; minimum 1).
- SW, $clog2(NUM_S) or 1 if NUM_S=1, slave index width (derived).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- ARADDR_M  in  NUM_M*ADDR_W  flattened master addresses; master i at [i*ADDR_W +: ADDR_W].
- ARLEN_M  in  NUM_M*8  flattened burst lengths.
- ARVALID_M  in  NUM_M  per-master AR valid.
- RREADY_M  in  NUM_M  per-master R ready.
- ARREADY_S  in  NUM_S  per-slave AR ready.
- RVALID_S  in  NUM_S  per-slave R valid.
- RLAST_S  in  NUM_S  per-slave R last.
- ar_busy  out  1  AR phase active toward a mapped slave.
- r_busy  out  1  R phase active from a mapped slave.
- m_idx  out  MW  granted master (valid when any busy/err flag is high).
- s_idx  out  SW  selected slave (valid with ar_busy/r_busy).
- err_arready  out  1  error-responder ARREADY to the granted master.
- err_rvalid  out  1  error-responder RVALID (RRESP=DECERR is implied by the mux).
- err_rlast  out  1  error-responder RLAST.

Behaviour:
- States: IDLE, ADDR, DATA, ERR_ADDR, ERR_DATA. All transitions occur on ACLK; ARESET has priority over every transition.
- Reset values:
  - state=IDLE, last_grant=0, beat counter=0.
  - All outputs 0: ar_busy, r_busy, err_arready, err_rvalid, err_rlast, m_idx, s_idx.
- IDLE with any ARVALID_M set:
  - Select winner g by the arbitration rule; latch m_idx=g and ARLEN_M[g].
  - Decode region = ARADDR_M[g] region field.
  - If region < NUM_S: s_idx=region, go to ADDR. Otherwise go to ERR_ADDR.
  - Grant latency: one cycle after ARVALID is first seen in IDLE.
- IDLE with no ARVALID_M set: remain in IDLE.
- ADDR: ar_busy=1. Leave on ARVALID_M[m_idx] && ARREADY_S[s_idx], going to DATA. There is no timeout; a master dropping ARVALID is a protocol violation and the block simply holds.
- DATA: r_busy=1. Leave on RREADY_M[m_idx] && RVALID_S[s_idx] && RLAST_S[s_idx], going to IDLE.
  - Non-last beats do not change state.
  - RVALID/RLAST from non-selected slaves are ignored.
- ERR_ADDR: err_arready=1 for exactly one cycle, then go to ERR_DATA with beat counter = latched ARLEN. ARVALID is guaranteed high by AXI stability.
- ERR_DATA: err_rvalid=1; err_rlast=1 when counter==0.
  - On RREADY_M[m_idx] with counter != 0: decrement the counter.
  - On RREADY_M[m_idx] with counter == 0: go to IDLE.
  - Beat count is exactly ARLEN+1. Master backpressure stalls the counter.
- Re-arbitration: earliest is the cycle after the last R handshake, since IDLE is revisited for one cycle. Back-to-back bursts therefore have a one-cycle bubble.
- Requests arriving outside IDLE wait; there is no preemption.
- last_grant updates only on leaving IDLE. Requests are evaluated only in IDLE.
- Reset asserted mid-burst: all state is abandoned and the next cycle is IDLE with outputs 0. The slave-side cleanup is the system's responsibility.
- Region field values >= NUM_S, including all-upper-bits nonzero, are treated as unmapped.

Optional Feature:
- Macro: AXI_READ_ARB_RR_EN.
- Defined: round-robin arbitration. The search order is last_grant+1, last_grant+2, ..., wrapping modulo NUM_M; the first requester found wins. Reset last_grant=0, so master 1 has first priority after reset.
- Undefined: fixed priority, highest-index requester always wins; last_grant is unused.

Test Plan:
- Fixed or RR, NUM_M=2/NUM_S=2:
  - M1 ARADDR=0x0001_0040, ARLEN=3, ARREADY_S1 after 2 cycles, S1 returns 4 beats with RLAST on beat 4.
  - Required: m_idx=1, s_idx=1, ar_busy for 3 cycles, r_busy until the 4th handshake, IDLE one cycle later.
- Decode error: M0 ARADDR=0x0005_0000, ARLEN=2, RREADY low for the first 2 cycles of ERR_DATA.
  - Required: err_arready one cycle, err_rvalid held, exactly 3 accepted beats, err_rlast only on the 3rd, then IDLE.
- RR, NUM_M=4: all four ARVALID held continuously with 1-beat bursts to S0.
  - Required grant order 1,2,3,0,1.
  - With the macro undefined, required order 3,3,3.
- Simultaneous: M0 and M1 request in the same cycle after reset with RR.
  - Required: M1 granted first, then M0 granted on the next IDLE.
- Reset mid-DATA: assert ARESET during beat 2 of a 4-beat S0 burst.
  - Required: next cycle state=IDLE and all outputs 0; a fresh M0 request to 0x0000_0000 is granted normally.
- Non-selected slave noise: during DATA for S0, pulse RVALID_S1 and RLAST_S1.
  - Required: no state change; completion only on the S0 RLAST handshake.

Source files
------------

// File: rtl/axi_read_arbiter_nxm.sv
// AXI read-path arbiter for NUM_M masters / NUM_S slaves with a built-in DECERR responder.
// Define AXI_READ_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (highest index wins).
module axi_read_arbiter_nxm #(
    parameter int NUM_M      = 2,
    parameter int NUM_S      = 2,
    parameter int ADDR_W     = 32,
    parameter int REGION_LSB = 16,
    parameter int MW         = (NUM_M > 2) ? $clog2(NUM_M) : 1,
    parameter int SW         = (NUM_S > 2) ? $clog2(NUM_S) : 1
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [NUM_M*ADDR_W-1:0] ARADDR_M,
    input  logic [NUM_M*8-1:0]      ARLEN_M,
    input  logic [NUM_M-1:0]        ARVALID_M,
    input  logic [NUM_M-1:0]        RREADY_M,
    input  logic [NUM_S-1:0]        ARREADY_S,
    input  logic [NUM_S-1:0]        RVALID_S,
    input  logic [NUM_S-1:0]        RLAST_S,
    output logic                    ar_busy,
    output logic                    r_busy,
    output logic [MW-1:0]           m_idx,
    output logic [SW-1:0]           s_idx,
    output logic                    err_arready,
    output logic                    err_rvalid,
    output logic                    err_rlast
);

    localparam int RW = ADDR_W - REGION_LSB;
    localparam logic [RW-1:0] NUM_S_R = RW'(NUM_S);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_ERR_ADDR = 3'd3;
    localparam logic [2:0] ST_ERR_DATA = 3'd4;

    logic [2:0]    state;
    logic [7:0]    len_q;
    logic [7:0]    beat_cnt;
    logic          grant_found;
    logic [MW-1:0] grant_idx;
    logic [RW-1:0] grant_region;
    logic [7:0]    grant_len;
    logic          addr_hs;
    logic          last_hs;
    logic          unused_addr_lsbs;

`ifdef AXI_READ_ARB_RR_EN
    logic [MW-1:0] last_grant;

    // Search starts one past the previous winner so every requester is served in turn.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            if (!grant_found && ARVALID_M[(int'(last_grant) + k) % NUM_M]) begin
                grant_found = 1'b1;
                grant_idx   = MW'((int'(last_grant) + k) % NUM_M);
            end
        end
    end
`else
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        grant_found = |ARVALID_M;
        grant_idx   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (ARVALID_M[i]) grant_idx = MW'(i);
        end
    end
`endif

    assign grant_region     = ARADDR_M[int'(grant_idx)*ADDR_W + REGION_LSB +: RW];
    assign grant_len        = ARLEN_M[int'(grant_idx)*8 +: 8];
    // Offset bits below the region field carry no routing information.
    assign unused_addr_lsbs = ^ARADDR_M;

    assign addr_hs = ARVALID_M[m_idx] && ARREADY_S[s_idx];
    assign last_hs = RREADY_M[m_idx] && RVALID_S[s_idx] && RLAST_S[s_idx];

    assign ar_busy     = (state == ST_ADDR);
    assign r_busy      = (state == ST_DATA);
    assign err_arready = (state == ST_ERR_ADDR);
    assign err_rvalid  = (state == ST_ERR_DATA);
    assign err_rlast   = (state == ST_ERR_DATA) && (beat_cnt == 8'd0);

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= ST_IDLE;
            m_idx    <= '0;
            s_idx    <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
`ifdef AXI_READ_ARB_RR_EN
            last_grant <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        m_idx <= grant_idx;
                        len_q <= grant_len;
`ifdef AXI_READ_ARB_RR_EN
                        last_grant <= grant_idx;
`endif
                        if (grant_region < NUM_S_R) begin
                            s_idx <= grant_region[SW-1:0];
                            state <= ST_ADDR;
                        end else begin
                            s_idx <= '0;
                            state <= ST_ERR_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (addr_hs) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (last_hs) state <= ST_IDLE;
                end
                ST_ERR_ADDR: begin
                    beat_cnt <= len_q;
                    state    <= ST_ERR_DATA;
                end
                ST_ERR_DATA: begin
                    // Master backpressure freezes the beat counter.
                    if (RREADY_M[m_idx]) begin
                        if (beat_cnt == 8'd0) state <= ST_IDLE;
                        else                  beat_cnt <= beat_cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter_nxm.sv
// Directed bench for axi_read_arbiter_nxm: a 2x2 instance for routing, DECERR and reset,
// and a 4x2 instance for arbitration order (fixed or round-robin, per AXI_READ_ARB_RR_EN).
module tb_axi_read_arbiter_nxm;

`ifdef AXI_READ_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // 2x2 instance
    logic        d2_rst;
    logic [63:0] d2_araddr;
    logic [15:0] d2_arlen;
    logic [1:0]  d2_arvalid, d2_rready, d2_arready_s, d2_rvalid_s, d2_rlast_s;
    logic        d2_ar_busy, d2_r_busy, d2_err_arready, d2_err_rvalid, d2_err_rlast;
    logic [0:0]  d2_m_idx, d2_s_idx;

    // 4x2 instance
    logic         d4_rst;
    logic [127:0] d4_araddr;
    logic [31:0]  d4_arlen;
    logic [3:0]   d4_arvalid, d4_rready;
    logic [1:0]   d4_arready_s, d4_rvalid_s, d4_rlast_s;
    logic         d4_ar_busy, d4_r_busy, d4_err_arready, d4_err_rvalid, d4_err_rlast;
    logic [1:0]   d4_m_idx;
    logic [0:0]   d4_s_idx;

    axi_read_arbiter_nxm #(.NUM_M(2), .NUM_S(2)) u_dut2 (
        .ACLK(clk), .ARESET(d2_rst),
        .ARADDR_M(d2_araddr), .ARLEN_M(d2_arlen), .ARVALID_M(d2_arvalid), .RREADY_M(d2_rready),
        .ARREADY_S(d2_arready_s), .RVALID_S(d2_rvalid_s), .RLAST_S(d2_rlast_s),
        .ar_busy(d2_ar_busy), .r_busy(d2_r_busy), .m_idx(d2_m_idx), .s_idx(d2_s_idx),
        .err_arready(d2_err_arready), .err_rvalid(d2_err_rvalid), .err_rlast(d2_err_rlast)
    );

    axi_read_arbiter_nxm #(.NUM_M(4), .NUM_S(2)) u_dut4 (
        .ACLK(clk), .ARESET(d4_rst),
        .ARADDR_M(d4_araddr), .ARLEN_M(d4_arlen), .ARVALID_M(d4_arvalid), .RREADY_M(d4_rready),
        .ARREADY_S(d4_arready_s), .RVALID_S(d4_rvalid_s), .RLAST_S(d4_rlast_s),
        .ar_busy(d4_ar_busy), .r_busy(d4_r_busy), .m_idx(d4_m_idx), .s_idx(d4_s_idx),
        .err_arready(d4_err_arready), .err_rvalid(d4_err_rvalid), .err_rlast(d4_err_rlast)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_d2_idle(input string tag);
        check({tag, "_ar_busy"},     32'(d2_ar_busy),     32'd0);
        check({tag, "_r_busy"},      32'(d2_r_busy),      32'd0);
        check({tag, "_m_idx"},       32'(d2_m_idx),       32'd0);
        check({tag, "_s_idx"},       32'(d2_s_idx),       32'd0);
        check({tag, "_err_arready"}, 32'(d2_err_arready), 32'd0);
        check({tag, "_err_rvalid"},  32'(d2_err_rvalid),  32'd0);
        check({tag, "_err_rlast"},   32'(d2_err_rlast),   32'd0);
    endtask

    task automatic clear_d2();
        d2_araddr = '0; d2_arlen = '0; d2_arvalid = '0; d2_rready = '0;
        d2_arready_s = '0; d2_rvalid_s = '0; d2_rlast_s = '0;
    endtask

    // Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
    initial begin
        int beats;
        int n_g;
        int grants[5];
        int exp_grants[5];
        logic prev;

        clear_d2();
        d4_araddr = '0; d4_arlen = '0; d4_arvalid = '0; d4_rready = '0;
        d4_arready_s = '0; d4_rvalid_s = '0; d4_rlast_s = '0;
        d2_rst = 1'b1;
        d4_rst = 1'b1;
        repeat (2) @(negedge clk);
        check_d2_idle("reset");
        check("reset_d4_ar_busy", 32'(d4_ar_busy), 32'd0);
        check("reset_d4_m_idx",   32'(d4_m_idx),   32'd0);
        d2_rst = 1'b0;
        d4_rst = 1'b0;

        // M1 to S1, ARLEN=3, slave ARREADY after 2 wait cycles, 4-beat burst
        d2_araddr[32 +: 32] = 32'h0001_0040;
        d2_arlen[8 +: 8]    = 8'd3;
        d2_arvalid          = 2'b10;
        @(negedge clk);
        check("t1_ar_busy_c1", 32'(d2_ar_busy), 32'd1);
        check("t1_m_idx",      32'(d2_m_idx),   32'd1);
        check("t1_s_idx",      32'(d2_s_idx),   32'd1);
        @(negedge clk);
        check("t1_ar_busy_c2", 32'(d2_ar_busy), 32'd1);
        @(negedge clk);
        check("t1_ar_busy_c3", 32'(d2_ar_busy), 32'd1);
        d2_arready_s[1] = 1'b1;
        @(negedge clk);
        check("t1_ar_busy_done", 32'(d2_ar_busy), 32'd0);
        check("t1_r_busy_start", 32'(d2_r_busy),  32'd1);
        d2_arvalid = '0;
        d2_arready_s = '0;
        d2_rvalid_s[1] = 1'b1;
        d2_rready[1] = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            d2_rlast_s[1] = (b == 4);
            @(negedge clk);
            check($sformatf("t1_r_busy_after_beat%0d", b), 32'(d2_r_busy), 32'(b < 4));
        end
        check("t1_idle_ar_busy", 32'(d2_ar_busy), 32'd0);
        clear_d2();

        // Decode error: M0 to region 5, ARLEN=2, RREADY low for the first 2 ERR_DATA cycles
        d2_araddr[0 +: 32] = 32'h0005_0000;
        d2_arlen[0 +: 8]   = 8'd2;
        d2_arvalid         = 2'b01;
        @(negedge clk);
        check("t2_err_arready", 32'(d2_err_arready), 32'd1);
        check("t2_m_idx",       32'(d2_m_idx),       32'd0);
        check("t2_no_ar_busy",  32'(d2_ar_busy),     32'd0);
        @(negedge clk);
        check("t2_err_arready_once", 32'(d2_err_arready), 32'd0);
        check("t2_err_rvalid_s1",    32'(d2_err_rvalid),  32'd1);
        check("t2_err_rlast_s1",     32'(d2_err_rlast),   32'd0);
        d2_arvalid = '0;
        @(negedge clk);
        check("t2_err_rvalid_s2", 32'(d2_err_rvalid), 32'd1);
        check("t2_err_rlast_s2",  32'(d2_err_rlast),  32'd0);
        d2_rready[0] = 1'b1;
        beats = 0;
        for (int c = 0; c < 10 && d2_err_rvalid; c++) begin
            beats++;
            check($sformatf("t2_err_rlast_beat%0d", beats), 32'(d2_err_rlast), 32'(beats == 3));
            @(negedge clk);
        end
        check("t2_beats",       32'(beats),         32'd3);
        check("t2_idle_rvalid", 32'(d2_err_rvalid), 32'd0);
        clear_d2();

        // Simultaneous M0/M1 requests right after reset, both held, single-beat bursts to S0
        d2_rst = 1'b1;
        @(negedge clk);
        d2_rst = 1'b0;
        d2_arvalid = 2'b11;
        d2_rready = 2'b11;
        d2_arready_s[0] = 1'b1;
        d2_rvalid_s[0] = 1'b1;
        d2_rlast_s[0] = 1'b1;
        n_g = 0;
        prev = 1'b0;
        grants = '{default: 99};
        for (int c = 0; c < 30 && n_g < 2; c++) begin
            @(negedge clk);
            if (d2_ar_busy && !prev) begin
                grants[n_g] = int'(d2_m_idx);
                n_g++;
            end
            prev = d2_ar_busy;
        end
        check("t3_grant_count", 32'(n_g),       32'd2);
        check("t3_grant0",      32'(grants[0]), 32'd1);
        check("t3_grant1",      32'(grants[1]), RR ? 32'd0 : 32'd1);
        clear_d2();
        d2_rst = 1'b1;
        @(negedge clk);
        d2_rst = 1'b0;

        // Reset mid-DATA: M1 4-beat burst from S0, reset during beat 2
        d2_araddr[32 +: 32] = 32'h0000_0100;
        d2_arlen[8 +: 8]    = 8'd3;
        d2_arvalid          = 2'b10;
        d2_arready_s[0]     = 1'b1;
        @(negedge clk);
        check("t4_ar_busy", 32'(d2_ar_busy), 32'd1);
        check("t4_m_idx",   32'(d2_m_idx),   32'd1);
        @(negedge clk);
        check("t4_r_busy", 32'(d2_r_busy), 32'd1);
        d2_arvalid = '0;
        d2_arready_s = '0;
        d2_rvalid_s[0] = 1'b1;
        d2_rready[1] = 1'b1;
        @(negedge clk);
        d2_rst = 1'b1;
        @(negedge clk);
        check_d2_idle("t4_after_rst");
        d2_rst = 1'b0;
        clear_d2();

        // Fresh M0 request to 0x0, with noise from S1 while in DATA for S0
        d2_arvalid      = 2'b01;
        d2_arready_s[0] = 1'b1;
        @(negedge clk);
        check("t5_ar_busy", 32'(d2_ar_busy), 32'd1);
        check("t5_m_idx",   32'(d2_m_idx),   32'd0);
        check("t5_s_idx",   32'(d2_s_idx),   32'd0);
        @(negedge clk);
        check("t5_r_busy", 32'(d2_r_busy), 32'd1);
        d2_arvalid = '0;
        d2_arready_s = '0;
        d2_rready[0] = 1'b1;
        d2_rvalid_s = 2'b10;
        d2_rlast_s = 2'b10;
        @(negedge clk);
        check("t5_noise_ignored", 32'(d2_r_busy), 32'd1);
        d2_rvalid_s = 2'b01;
        d2_rlast_s = 2'b00;
        @(negedge clk);
        check("t5_nonlast_beat", 32'(d2_r_busy), 32'd1);
        d2_rlast_s = 2'b01;
        @(negedge clk);
        check("t5_done_r_busy",  32'(d2_r_busy),  32'd0);
        check("t5_done_ar_busy", 32'(d2_ar_busy), 32'd0);
        clear_d2();

        // Four masters requesting continuously, single-beat bursts to S0
        d4_arvalid = 4'hf;
        d4_rready = 4'hf;
        d4_arready_s[0] = 1'b1;
        d4_rvalid_s[0] = 1'b1;
        d4_rlast_s[0] = 1'b1;
        exp_grants = RR ? '{1, 2, 3, 0, 1} : '{3, 3, 3, 3, 3};
        n_g = 0;
        prev = 1'b0;
        grants = '{default: 99};
        for (int c = 0; c < 60 && n_g < 5; c++) begin
            @(negedge clk);
            if (d4_ar_busy && !prev) begin
                grants[n_g] = int'(d4_m_idx);
                n_g++;
            end
            prev = d4_ar_busy;
        end
        check("t6_grant_count", 32'(n_g), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t6_grant%0d", i), 32'(grants[i]), 32'(exp_grants[i]));
        end
        d4_arvalid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
